uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter among NREQ byte sources. Round-robin arbitration with
//  bounded per-owner bursts. Sequences the transmitter via a one-cycle tx_start pulse
//  and waits for tx_done before issuing the next byte. A watchdog recovers from a
//  transmitter that never completes. Sits between client logic and the uart_tx core.
// PARAMETERS
//  NREQ     4      number of requesters (2..16)
//  dbits    8      data bits per UART frame
//  BURST    4      max consecutive bytes granted to one owner before rotating (>=1)
//  TIMEOUT  65535  clk cycles allowed in WAIT for tx_done before abort (>=2)
// PORTS
//  clk       in   1             system clock, all logic on posedge
//  rst       in   1             asynchronous, active-high reset
//  req       in   NREQ          req[i]=1: requester i holds a valid byte
//  req_data  in   NREQ*dbits    byte of requester i at [i*dbits +: dbits]
//  ack       out  NREQ          one-hot, 1-cycle pulse: byte of requester i captured
//  tx_start  out  1             1-cycle pulse to transmitter, tx_din valid while high
//  tx_din    out  dbits         byte to transmitter, held stable until next capture
//  tx_done   in   1             transmitter completion pulse
//  busy      out  1             1 whenever state != IDLE
//  owner     out  clog2(NREQ)   index of current/last granted requester
//  err       out  1             sticky: watchdog timeout occurred; cleared only by rst
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; ack=0, tx_start=0, tx_din=0, busy=0, owner=0,
//   err=0, burst_cnt=0, wd_cnt=0, rr_ptr=0 (search starts at requester 0).
//  FSM, all outputs registered:
//   IDLE : if req!=0, select winner w and capture at the edge: tx_din<=req_data[w],
//          owner<=w, ack<=onehot(w); go START. If req==0, stay; ack=0.
//   START: tx_start=1 for exactly this cycle; wd_cnt<=0; go WAIT.
//   WAIT : tx_start=0; wd_cnt++. On tx_done: burst_cnt++ and go IDLE.
//          If wd_cnt reaches TIMEOUT-1 without tx_done: err<=1, burst_cnt<=0,
//          rr_ptr<=owner+1 (mod NREQ), go IDLE (byte counted as lost).
//  Winner selection in IDLE:
//   - If req[owner]=1 and burst_cnt<BURST and the previous cycle was not an abort:
//     w=owner (burst continues).
//   - Otherwise: w = first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... wrapping
//     mod NREQ; burst_cnt<=0 on change of owner; rr_ptr<=w+1 (mod NREQ).
//   - BURST=1 gives pure round-robin. A lone requester is re-granted indefinitely
//     (burst_cnt resets when no other req is pending at selection time).
//  Latency: req rises in IDLE -> ack and tx_din next edge -> tx_start the following
//   cycle. Minimum byte-to-byte spacing = 3 cycles + transmitter duration.
//  Requester contract: after seeing ack[i]=1, requester must present its next byte or
//   drop req[i] by the following edge; req_data is sampled only on the capture edge.
//  tx_done outside WAIT is ignored. tx_done and timeout on the same cycle: tx_done wins,
//   err unchanged.
//  req changes during START/WAIT have no effect until next IDLE evaluation.
//  rst mid-frame: FSM aborts immediately; transmitter reset is its owner's concern.
// TESTING
//  1 Reset: rst=1 mid-WAIT -> all outputs 0 and state IDLE asynchronously, no tx_start.
//  2 Single byte: req=0001, data0=8'hA5 -> ack=0001 at edge 1, tx_start at cycle 2,
//    tx_din=8'hA5; tx_done -> busy=0 next cycle.
//  3 Round-robin, BURST=1: req=1111 held, each requester's data distinct -> grant order
//    0,1,2,3,0,... each ack exactly once per tx_done.
//  4 Burst, BURST=4: req=0011 held -> owner 0 gets 4 bytes, then owner 1 gets 4, then 0.
//  5 Watchdog, TIMEOUT=16: no tx_done -> err=1 after 16 WAIT cycles, IDLE, next grant
//    goes to owner+1 if requesting; err stays 1 until rst.
//  6 Simultaneous: tx_done on the timeout cycle -> err=0, burst_cnt incremented.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NREQ byte sources. Round-robin
//   arbitration with bounded per-owner bursts. The transmitter is started
//   with a one-cycle tx_start pulse, and the next byte is not issued until
//   tx_done is seen. A watchdog recovers from a transmitter that never
//   completes.
//
// Ports
//   clk       in   1             system clock, rising edge
//   rst       in   1             asynchronous, active-high reset
//   req       in   NREQ          req[i]=1: requester i holds a valid byte
//   req_data  in   NREQ*dbits    byte of requester i at [i*dbits +: dbits]
//   ack       out  NREQ          one-hot pulse: byte of requester i captured
//   tx_start  out  1             pulse to transmitter, tx_din valid while high
//   tx_din    out  dbits         byte to transmitter, held until next capture
//   tx_done   in   1             transmitter completion pulse
//   busy      out  1             high whenever the FSM is not idle
//   owner     out  clog2(NREQ)   index of current/last granted requester
//   err       out  1             sticky watchdog-timeout flag, cleared by rst
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int dbits   = 8,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 65535,
  localparam int OW     = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*dbits-1:0]   req_data,
  output logic [NREQ-1:0]         ack,
  output logic                    tx_start,
  output logic [dbits-1:0]        tx_din,
  input  logic                    tx_done,
  output logic                    busy,
  output logic [OW-1:0]           owner,
  output logic                    err
);

  localparam int BW = $clog2(BURST + 1);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_burst_cnt;
  logic [WW-1:0]   r_wd_cnt;
  logic [OW-1:0]   r_rr_ptr;
  logic            r_abort;   // previous cycle ended a frame by timeout

  logic [dbits-1:0] w_bytes [NREQ];
  logic             w_keep;
  logic             w_scan_hit;
  logic [OW-1:0]    w_scan_idx;
  logic [OW-1:0]    w_k;
  logic [OW-1:0]    w_win;
  logic [OW-1:0]    w_next_ptr;
  logic [OW-1:0]    w_owner_next;

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] x);
    return (x == OW'(NREQ - 1)) ? '0 : x + OW'(1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_bytes[i] = req_data[i*dbits +: dbits];
    end
  end

  // Winner: the current owner keeps the grant while its burst budget lasts
  // (and it was not just aborted); otherwise first requester from r_rr_ptr.
  always_comb begin
    w_keep     = req[owner] && (r_burst_cnt < BW'(BURST)) && !r_abort;
    w_scan_hit = 1'b0;
    w_scan_idx = '0;
    w_k        = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_k = OW'((32'(r_rr_ptr) + i) % NREQ);
      if (!w_scan_hit && req[w_k]) begin
        w_scan_hit = 1'b1;
        w_scan_idx = w_k;
      end
    end
    w_win        = w_keep ? owner : w_scan_idx;
    w_next_ptr   = next_idx(w_win);
    w_owner_next = next_idx(owner);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= '0;
      r_wd_cnt    <= '0;
      r_rr_ptr    <= '0;
      r_abort     <= 1'b0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_din      <= '0;
      busy        <= 1'b0;
      owner       <= '0;
      err         <= 1'b0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      r_abort  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            tx_din   <= w_bytes[w_win];
            owner    <= w_win;
            ack      <= NREQ'(1) << w_win;
            // Pointer always advances past the winner so an exhausted burst
            // rotates away even when the first grant came via the keep path.
            r_rr_ptr <= w_next_ptr;
            // Scan path restarts the burst; this also covers a lone
            // requester being re-granted after exhausting its budget.
            if (!w_keep) r_burst_cnt <= '0;
            busy     <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          tx_start <= 1'b1;
          r_wd_cnt <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            r_burst_cnt <= r_burst_cnt + BW'(1);
            busy        <= 1'b0;
            r_state     <= S_IDLE;
          end else if (r_wd_cnt == WW'(TIMEOUT - 1)) begin
            err         <= 1'b1;
            r_burst_cnt <= '0;
            r_rr_ptr    <= w_owner_next;
            r_abort     <= 1'b1;
            busy        <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + WW'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  // instance A: BURST=1 (pure round-robin); instance B: BURST=4
  logic [3:0]  req_a, req_b, ack_a, ack_b;
  logic [31:0] data_a, data_b;
  logic        start_a, start_b, done_a, done_b;
  logic        busy_a, busy_b, err_a, err_b;
  logic [7:0]  din_a, din_b;
  logic [1:0]  own_a, own_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(4), .dbits(8), .BURST(1), .TIMEOUT(16)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .req_data(data_a), .ack(ack_a),
    .tx_start(start_a), .tx_din(din_a), .tx_done(done_a), .busy(busy_a),
    .owner(own_a), .err(err_a)
  );

  uart_tx_arbiter #(.NREQ(4), .dbits(8), .BURST(4), .TIMEOUT(16)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .req_data(data_b), .ack(ack_b),
    .tx_start(start_b), .tx_din(din_b), .tx_done(done_b), .busy(busy_b),
    .owner(own_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel=1 selects instance A. Waits (bounded) for ack, checks the grant,
  // checks the tx_start pulse, then completes the frame with tx_done.
  task automatic serve(input bit sel, input logic [1:0] eo, input logic [7:0] ed,
                       input string tag);
    int unsigned n = 0;
    while (((sel ? ack_a : ack_b) == 4'b0) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " ack"},   sel ? ack_a : ack_b, 32'(4'b0001 << eo));
    chk({tag, " owner"}, sel ? own_a : own_b, eo);
    chk({tag, " din"},   sel ? din_a : din_b, ed);
    tick();
    chk({tag, " start"}, sel ? start_a : start_b, 1);
    tick();
    tick();
    if (sel) done_a = 1'b1; else done_b = 1'b1;
    tick();
    done_a = 1'b0;
    done_b = 1'b0;
    chk({tag, " idle"}, sel ? busy_a : busy_b, 0);
  endtask

  task automatic wait_ack_b();
    int unsigned n = 0;
    while (ack_b == 4'b0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_a = '0; req_b = '0; data_a = '0; data_b = '0;
    done_a = 1'b0; done_b = 1'b0;
    #1;
    chk("rst ack",   ack_b, 0);
    chk("rst start", start_b, 0);
    chk("rst din",   din_b, 0);
    chk("rst busy",  busy_b, 0);
    chk("rst owner", own_b, 0);
    chk("rst err",   err_b, 0);
    chk("rst busyA", busy_a, 0);
    tick();
    tick();
    rst = 1'b0;

    // single byte
    req_b = 4'b0001;
    data_b = 32'h0000_00A5;
    tick();
    chk("single ack",    ack_b, 4'b0001);
    chk("single din",    din_b, 8'hA5);
    chk("single busy",   busy_b, 1);
    chk("single nostart", start_b, 0);
    req_b = 4'b0000;
    tick();
    chk("single start", start_b, 1);
    chk("single din2",  din_b, 8'hA5);
    tick();
    chk("single start_end", start_b, 0);
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    chk("single idle", busy_b, 0);

    // watchdog: owner 0 times out, requester 1 gets the next grant
    req_b = 4'b0011;
    data_b = 32'h0000_2211;
    wait_ack_b();
    chk("wd ack0", ack_b, 4'b0001);
    repeat (16) tick();
    chk("wd err_before",  err_b, 0);
    chk("wd busy_before", busy_b, 1);
    tick();
    chk("wd err_set", err_b, 1);
    chk("wd idle",    busy_b, 0);
    tick();
    chk("wd next_ack", ack_b, 4'b0010);
    serve(1'b0, 2'd1, 8'h22, "wd next");
    chk("wd err_sticky", err_b, 1);

    // asynchronous reset in the middle of WAIT
    wait_ack_b();
    tick();
    chk("arst pre_start", start_b, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst ack",   ack_b, 0);
    chk("arst start", start_b, 0);
    chk("arst din",   din_b, 0);
    chk("arst busy",  busy_b, 0);
    chk("arst owner", own_b, 0);
    chk("arst err",   err_b, 0);
    req_b = 4'b0000;
    tick();
    chk("arst held_start", start_b, 0);
    rst = 1'b0;

    // tx_done on the timeout cycle: counted as success, burst advances
    req_b = 4'b0011;
    wait_ack_b();
    chk("sim ack0", ack_b, 4'b0001);
    repeat (16) tick();
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    chk("sim err",  err_b, 0);
    chk("sim idle", busy_b, 0);
    serve(1'b0, 2'd0, 8'h11, "sim b2");
    serve(1'b0, 2'd0, 8'h11, "sim b3");
    serve(1'b0, 2'd0, 8'h11, "sim b4");
    serve(1'b0, 2'd1, 8'h22, "sim rot");

    // burst of 4 per owner
    rst = 1'b1;
    req_b = 4'b0000;
    tick();
    rst = 1'b0;
    req_b = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      if ((k / 4) % 2 == 0) serve(1'b0, 2'd0, 8'h11, "burst");
      else                  serve(1'b0, 2'd1, 8'h22, "burst");
    end
    req_b = 4'b0000;

    // pure round-robin on instance A
    data_a = 32'hA3A2_A1A0;
    req_a = 4'b1111;
    serve(1'b1, 2'd0, 8'hA0, "rr 0");
    serve(1'b1, 2'd1, 8'hA1, "rr 1");
    serve(1'b1, 2'd2, 8'hA2, "rr 2");
    serve(1'b1, 2'd3, 8'hA3, "rr 3");
    serve(1'b1, 2'd0, 8'hA0, "rr 4");
    serve(1'b1, 2'd1, 8'hA1, "rr 5");
    req_a = 4'b0000;
    chk("rr errA", err_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
